// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: accepts one request per two cycles and writes the encoded word to instruction memory.
// One cycle from accept to mem_we; in_ready is high only in IDLE, and invalid kinds are dropped and flagged in err.
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       word_q, word_d;
  logic [31:0]       enc_word;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              kind_ok;
  logic              accept;
  logic              full;

  always_comb begin
    enc_word = '0;
    kind_ok  = 1'b1;
    case (kind)
      3'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      3'd1:    enc_word = {6'b100011, rs, rt, imm};
      3'd2:    enc_word = {6'b101011, rs, rt, imm};
      3'd3:    enc_word = {6'b000100, rs, rt, imm};
      3'd4:    enc_word = {6'b001000, rs, rt, imm};
      3'd5:    enc_word = {6'b000010, target};
      default: kind_ok  = 1'b0;
    endcase
  end

  assign accept    = in_valid && (state_q == IDLE);
  assign count_inc = count_q + 1'b1;
  assign full      = (count_inc == (ADDR_W + 1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (kind_ok) begin
            word_d  = enc_word;
            last_d  = last;
            state_d = WRITE;
          end else begin
            // Invalid kinds are discarded entirely, including their last bit.
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        count_d = count_inc;
        // Hold the pointer on the final slot so it never wraps back to zero.
        ptr_d   = full ? ptr_q : ptr_q + 1'b1;
        state_d = (last_q || full) ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign mem_we   = (state_q == WRITE);
  assign mem_addr = ptr_q;
  assign mem_wd   = word_q;
  assign count    = count_q;
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, 64, number of instruction-memory words written (power of two).
REQ-002 SHALL have parameter: ADDR_W, 6, log2(DEPTH).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  request carries valid fields.
REQ-006 SHALL have port: in_ready  output  1  encoder can accept a request.
REQ-007 SHALL have port: kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J; 6-7 invalid.
REQ-008 SHALL have ports: rs, rt, rd  input  5 each  register fields.
REQ-009 SHALL have ports: funct  input  6; imm  input  16; target  input  26.
REQ-010 SHALL have port: last  input  1  final instruction of program.
REQ-011 SHALL have ports: mem_we  output  1; mem_addr  output  ADDR_W  word address; mem_wd  output  32  write data.
REQ-012 SHALL have ports: count  output  ADDR_W+1  words written; done  output  1; err  output  1  sticky invalid-kind flag.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, DONE; in_ready=1 only in IDLE.
REQ-014 Handshake SHALL complete on an edge where in_valid=1 and in_ready=1; in_valid SHALL be ignored otherwise.
REQ-015 On accept with valid kind, SHALL register the encoded word and go to WRITE.
REQ-016 Encoding SHALL be: RTYPE {000000,rs,rt,rd,00000,funct}; LW {100011,rs,rt,imm}; SW {101011,rs,rt,imm}; BEQ {000100,rs,rt,imm}; ADDI {001000,rs,rt,imm}; J {000010,target}.
REQ-017 Fields unused by a kind (e.g. rd/funct for LW, rs/rt/imm for J) SHALL NOT affect the encoded word.
REQ-018 In WRITE, SHALL drive mem_we=1 for exactly one cycle, mem_addr=write pointer, mem_wd=encoded word; latency accept-edge to mem_we is one cycle.
REQ-019 Leaving WRITE, pointer and count SHALL increment by 1; next state SHALL be DONE if last was set on the accepted request or count reaches DEPTH, else IDLE.
REQ-020 Throughput SHALL be one instruction per two cycles.
REQ-021 mem_we SHALL be 0 in IDLE and DONE; mem_addr and mem_wd are don't-care when mem_we=0.
REQ-022 On accept with kind 6 or 7: err SHALL set and stay set until reset; request SHALL be dropped including its last bit; state stays IDLE; pointer and count unchanged.
REQ-023 DONE SHALL hold done=1, in_ready=0 until reset; no further writes.
REQ-024 Pointer SHALL never wrap: the DEPTH-th write (address DEPTH-1) forces DONE with count=DEPTH.

Reset
REQ-025 Reset SHALL force IDLE, pointer=0, count=0, done=0, err=0, mem_we=0 on the next edge, including during WRITE (that write is abandoned after the reset edge).
REQ-026 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-027 Reset, accept RTYPE rs=1 rt=2 rd=3 funct=0x20 -> next cycle mem_we=1, addr=0, wd=0x00221820; then count=1, in_ready=1.
REQ-028 Then LW rs=0 rt=8 imm=0x0004 -> addr=1, wd=0x8C080004; count=2.
REQ-029 J target=0x0000010 with last=1 -> wd=0x08000010, then done=1, in_ready=0; further in_valid produces no mem_we.
REQ-030 kind=7 with last=1 -> no mem_we, err=1, count unchanged, in_ready stays 1, done=0.
REQ-031 64 back-to-back ADDI (rs=0, rt=1, imm=i) -> addresses 0..63, wd=0x2001000i-pattern, done=1, count=64 after 64th write.
REQ-032 Reset asserted during WRITE -> after the reset edge mem_we=0, count=0, next accepted request writes addr=0.
